dsp_route_sequencer: RTL and testbench
======================================

DSP_ROUTE_SEQUENCER -- requirements
Module: dsp_route_sequencer

Interface
REQ-001 SHALL have parameter MODULES, default 8: number of DSP submodules behind the routing bus.
REQ-002 SHALL have parameter LOG_MODULES, default 4: width of one input-select code.
REQ-003 SHALL derive SLOTS = MODULES+4 (inputs: modules, scope1/2, pwm0/1) and OSLOTS = MODULES+2 (direct outputs: modules, asg1/2).
REQ-004 SHALL have port clk_i, input, 1: processing clock; reset is asynchronous and active-high.
REQ-005 SHALL have port rst_i, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port sys_addr, input, 32: bus address; only bits [15:0] are decoded.
REQ-007 SHALL have port sys_wdata, input, 32: bus write data.
REQ-008 SHALL have port sys_wen, input, 1: bus write enable, single-cycle pulse.
REQ-009 SHALL have port sys_ren, input, 1: bus read enable, single-cycle pulse.
REQ-010 SHALL have port sys_rdata, output, 32: bus read data.
REQ-011 SHALL have port sys_ack, output, 1: bus acknowledge.
REQ-012 SHALL have port sys_err, output, 1: bus error, constant 0.
REQ-013 SHALL have port sel_o, output, SLOTS*LOG_MODULES: active input-select table; slot k occupies bits [k*LOG_MODULES +: LOG_MODULES].
REQ-014 SHALL have port osel_o, output, OSLOTS*2: active output-select table; bit0 = DAC1, bit1 = DAC2.
REQ-015 SHALL have port mute_o, output, 1: high to force the DAC sum to zero during reconfiguration.
REQ-016 SHALL have port busy_o, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-017 SHALL hold shadow tables, writable at offsets 0x00+4k (select, k<SLOTS, wdata[LOG_MODULES-1:0]) and 0x40+4k (osel, k<OSLOTS, wdata[1:0]); reads of these offsets SHALL return the shadow value.
REQ-018 SHALL decode the following registers: 0x80 CTRL (write bit0=1 requests commit; self-clearing); 0x84 MUTE_CYC (16 bits, read/write); 0x88 STATUS (read-only: bit0 busy, bit1 pending, bit2 arm); 0x8C COMMITS (16-bit count of completed APPLY steps, wraps at 0xFFFF->0).
REQ-019 SHALL assert sys_ack exactly one cycle after any sys_wen or sys_ren; unmapped offsets SHALL read 0 and ignore writes.
REQ-020 SHALL run an FSM with states IDLE, MUTE, APPLY and SETTLE.
REQ-021 In IDLE, the FSM SHALL go to MUTE on a commit request or pending=1; with MUTE_CYC=0 it SHALL go directly to APPLY.
REQ-022 In MUTE, the FSM SHALL assert mute_o and load the counter with MUTE_CYC; it SHALL go to APPLY when the counter reaches 1, so mute_o precedes APPLY by exactly MUTE_CYC cycles.
REQ-023 APPLY SHALL last 1 cycle, copy both shadow tables to the active tables in that cycle, increment COMMITS, and go to SETTLE (or to IDLE when MUTE_CYC=0).
REQ-024 SETTLE SHALL hold mute_o for MUTE_CYC cycles, then go to IDLE; mute_o SHALL be low in IDLE.
REQ-025 A commit request while busy SHALL set pending; pending SHALL be cleared on entry to MUTE/APPLY, and only one request SHALL be queued.
REQ-026 Shadow writes while busy SHALL be accepted; the values present in the APPLY cycle SHALL be the ones that take effect.
REQ-027 Active tables SHALL change only in APPLY, all slots in the same cycle, with no partial update.
REQ-028 MUTE_CYC SHALL be sampled at entry to MUTE; a write during MUTE or SETTLE SHALL affect only the next sequence.
REQ-029 A commit request and a shadow write in the same cycle SHALL both take effect.
REQ-030 Outputs SHALL be registered: sel_o, osel_o, mute_o and busy_o driven from flops.

Reset
REQ-031 rst_i SHALL asynchronously force the following values:
- FSM: IDLE, with pending=0, arm=0, counter=0, COMMITS=0 and MUTE_CYC=0.
- mute_o, busy_o, sys_ack and sys_rdata: 0.
- Active and shadow select tables: slots 1 and 3 and SCOPE2 = MODULES+3 (ADC2); PWM slots = 2**LOG_MODULES-1 (NONE); all other slots = MODULES+2 (ADC1).
- osel: all entries 0.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence with no APPLY, and return the active tables to reset values.

Configuration
REQ-033 With macro DSP_ROUTE_TRIG_EN defined, the block SHALL implement a hardware-triggered commit:
- It SHALL add port trig_i, input, 1.
- CTRL bit1 write=1 SHALL set arm.
- The first rising edge of trig_i while arm=1 SHALL raise a commit request and clear arm.
- The edge detector SHALL register trig_i, and the commit SHALL be raised in the cycle after the edge is detected.
REQ-034 Without DSP_ROUTE_TRIG_EN, trig_i SHALL be absent, CTRL bit1 SHALL be ignored, and STATUS bit2 SHALL read 0.

Verification
REQ-035 Reset then read 0x00, 0x04, 0x24 and 0x2C -> 10, 11, 11, 15; sel_o slot 0 = 10; osel_o = 0.
REQ-036 Write shadow slot 0 = 4 with MUTE_CYC=3, then commit -> mute_o high 3 cycles, sel_o slot 0 = 4 in the APPLY cycle, mute_o high 3 more cycles, COMMITS=1, busy_o then low.
REQ-037 Commit twice during MUTE -> pending=1, exactly two sequences run back-to-back, COMMITS=2.
REQ-038 MUTE_CYC=0 with commit -> active tables update 1 cycle after the request, mute_o never asserts.
REQ-039 Assert rst_i during SETTLE -> mute_o=0 immediately, sel_o at reset values, COMMITS=0.
REQ-040 With DSP_ROUTE_TRIG_EN: arm, pulse trig_i twice -> exactly one sequence runs, arm=0 afterwards.

Source files
------------

// File: rtl/dsp_route_sequencer_if.sv
// Register bus between a host and dsp_route_sequencer.
//   sys_addr  : byte address; the slave decodes bits [15:0] only
//   sys_wdata : write data
//   sys_wen   : write strobe, single-cycle pulse
//   sys_ren   : read strobe, single-cycle pulse
//   sys_rdata : read data, valid together with sys_ack
//   sys_ack   : acknowledge, one cycle after each strobe
//   sys_err   : error flag, never raised
interface dsp_route_sequencer_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_ack;
  logic        sys_err;

  modport master (
    output sys_addr, sys_wdata, sys_wen, sys_ren,
    input  sys_rdata, sys_ack, sys_err
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_wen, sys_ren,
    output sys_rdata, sys_ack, sys_err
  );
endinterface

// File: rtl/dsp_route_sequencer.sv
// Glitch-free reconfiguration of the DSP routing matrix. Software fills
// shadow select tables over the register bus, then requests a commit; the
// sequencer mutes the DAC sum, swaps all shadow entries into the active
// tables in one cycle, and keeps the mute for a settling period.
//
// Ports:
//   clk_i  : processing clock
//   rst_i  : asynchronous active-high reset
//   trig_i : hardware commit trigger (only with DSP_ROUTE_TRIG_EN)
//   bus    : register bus, slave side
//   sel_o  : active input-select table, slot k at [k*LOG_MODULES +: LOG_MODULES]
//   osel_o : active output-select table, 2 bits per slot (bit0 DAC1, bit1 DAC2)
//   mute_o : forces the DAC sum to zero while reconfiguring
//   busy_o : sequencer not idle
//
// Register map (offsets on sys_addr[15:0]):
//   0x00+4k  select shadow slot k      0x40+4k  output-select shadow slot k
//   0x80     CTRL   (bit0 commit, bit1 arm trigger)
//   0x84     MUTE_CYC                  0x88     STATUS {arm, pending, busy}
//   0x8C     COMMITS
//
// Build option: define DSP_ROUTE_TRIG_EN to add trig_i and the armed
// hardware-triggered commit.
module dsp_route_sequencer #(
  parameter  int unsigned MODULES     = 8,
  parameter  int unsigned LOG_MODULES = 4,
  localparam int unsigned SLOTS       = MODULES + 4,
  localparam int unsigned OSLOTS      = MODULES + 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
`ifdef DSP_ROUTE_TRIG_EN
  input  logic                         trig_i,
`endif
  dsp_route_sequencer_if.slave         bus,
  output logic [SLOTS*LOG_MODULES-1:0] sel_o,
  output logic [OSLOTS*2-1:0]          osel_o,
  output logic                         mute_o,
  output logic                         busy_o
);

  typedef enum logic [1:0] {IDLE, MUTE, APPLY, SETTLE} state_e;

  // Reset routing: slots 1, 3 and SCOPE2 take ADC2, PWM slots take NONE,
  // everything else takes ADC1.
  function automatic logic [SLOTS*LOG_MODULES-1:0] sel_reset_table();
    logic [SLOTS*LOG_MODULES-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (k == 1 || k == 3 || k == MODULES + 1)
        t[k*LOG_MODULES +: LOG_MODULES] = LOG_MODULES'(MODULES + 3);
      else if (k >= MODULES + 2)
        t[k*LOG_MODULES +: LOG_MODULES] = '1;
      else
        t[k*LOG_MODULES +: LOG_MODULES] = LOG_MODULES'(MODULES + 2);
    end
    return t;
  endfunction

  localparam logic [SLOTS*LOG_MODULES-1:0] SEL_RST = sel_reset_table();

  state_e                       state_q, state_d;
  logic                         pending_q, pending_d;
  logic [15:0]                  cnt_q, cnt_d;
  logic [15:0]                  mlen_q, mlen_d;
  logic [15:0]                  mute_cyc_q;
  logic [15:0]                  commits_q;
  logic [SLOTS*LOG_MODULES-1:0] sel_shadow_q, sel_shadow_d;
  logic [OSLOTS*2-1:0]          osel_shadow_q, osel_shadow_d;
  logic [SLOTS*LOG_MODULES-1:0] sel_q;
  logic [OSLOTS*2-1:0]          osel_q;
  logic                         mute_q, busy_q;
  logic                         ack_q;
  logic [31:0]                  rdata_q;
  logic [31:0]                  rd_data;
  logic [15:0]                  off;
  logic                         ctrl_wr;
  logic                         commit_req;
  logic                         arm_bit;
  logic                         trig_req;
  logic                         unused_bits;

  assign off         = bus.sys_addr[15:0];
  assign ctrl_wr     = bus.sys_wen && (off == 16'h0080);
  assign commit_req  = (ctrl_wr && bus.sys_wdata[0]) || trig_req;
  assign unused_bits = ^{bus.sys_addr[31:16], bus.sys_wdata[31:16]};

`ifdef DSP_ROUTE_TRIG_EN
  logic trig_q, trig_req_q, arm_q;
  logic trig_edge;

  assign trig_edge = trig_i && !trig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trig_q     <= 1'b0;
      trig_req_q <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      trig_q     <= trig_i;
      trig_req_q <= trig_edge && arm_q;
      if (ctrl_wr && bus.sys_wdata[1])
        arm_q <= 1'b1;
      else if (trig_edge)
        arm_q <= 1'b0;
    end
  end

  assign arm_bit  = arm_q;
  assign trig_req = trig_req_q;
`else
  assign arm_bit  = 1'b0;
  assign trig_req = 1'b0;
`endif

  // Shadow tables with this cycle's bus write folded in.
  always_comb begin
    sel_shadow_d  = sel_shadow_q;
    osel_shadow_d = osel_shadow_q;
    if (bus.sys_wen) begin
      for (int unsigned k = 0; k < SLOTS; k++)
        if (off == 16'(4 * k))
          sel_shadow_d[k*LOG_MODULES +: LOG_MODULES] = bus.sys_wdata[LOG_MODULES-1:0];
      for (int unsigned k = 0; k < OSLOTS; k++)
        if (off == 16'(32'h40 + 4 * k))
          osel_shadow_d[k*2 +: 2] = bus.sys_wdata[1:0];
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      16'h0084: rd_data = {16'h0000, mute_cyc_q};
      16'h0088: rd_data = {29'd0, arm_bit, pending_q, busy_q};
      16'h008C: rd_data = {16'h0000, commits_q};
      default: begin
        for (int unsigned k = 0; k < SLOTS; k++)
          if (off == 16'(4 * k))
            rd_data = 32'(sel_shadow_q[k*LOG_MODULES +: LOG_MODULES]);
        for (int unsigned k = 0; k < OSLOTS; k++)
          if (off == 16'(32'h40 + 4 * k))
            rd_data = 32'(osel_shadow_q[k*2 +: 2]);
      end
    endcase
  end

  // mlen holds MUTE_CYC as sampled when the sequence started, so later
  // writes only affect the next sequence.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    mlen_d    = mlen_q;
    case (state_q)
      IDLE: begin
        if (commit_req || pending_q) begin
          pending_d = 1'b0;
          mlen_d    = mute_cyc_q;
          cnt_d     = mute_cyc_q;
          state_d   = (mute_cyc_q == 16'd0) ? APPLY : MUTE;
        end
      end
      MUTE: begin
        if (commit_req) pending_d = 1'b1;
        if (cnt_q <= 16'd1) state_d = APPLY;
        else                cnt_d   = cnt_q - 16'd1;
      end
      APPLY: begin
        if (commit_req) pending_d = 1'b1;
        if (mlen_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          state_d = SETTLE;
          cnt_d   = mlen_q;
        end
      end
      SETTLE: begin
        if (commit_req) pending_d = 1'b1;
        if (cnt_q <= 16'd1) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      mlen_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      mlen_q    <= mlen_d;
    end
  end

  // Registered outputs are loaded from the next state so they line up with
  // the state they describe; the active tables therefore take the forwarded
  // shadow value on the edge that enters APPLY.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_shadow_q  <= SEL_RST;
      osel_shadow_q <= '0;
      sel_q         <= SEL_RST;
      osel_q        <= '0;
      mute_q        <= 1'b0;
      busy_q        <= 1'b0;
      commits_q     <= '0;
      mute_cyc_q    <= '0;
      ack_q         <= 1'b0;
      rdata_q       <= '0;
    end else begin
      sel_shadow_q  <= sel_shadow_d;
      osel_shadow_q <= osel_shadow_d;
      if (state_d == APPLY) begin
        sel_q     <= sel_shadow_d;
        osel_q    <= osel_shadow_d;
        commits_q <= commits_q + 16'd1;
      end
      mute_q <= (state_d == MUTE) || (state_d == SETTLE) ||
                ((state_d == APPLY) && (mlen_d != 16'd0));
      busy_q <= (state_d != IDLE);
      if (bus.sys_wen && off == 16'h0084)
        mute_cyc_q <= bus.sys_wdata[15:0];
      ack_q   <= bus.sys_wen || bus.sys_ren;
      rdata_q <= bus.sys_ren ? rd_data : '0;
    end
  end

  assign sel_o         = sel_q;
  assign osel_o        = osel_q;
  assign mute_o        = mute_q;
  assign busy_o        = busy_q;
  assign bus.sys_rdata = rdata_q;
  assign bus.sys_ack   = ack_q;
  assign bus.sys_err   = 1'b0;

endmodule

// File: tb/tb_dsp_route_sequencer.sv
// Directed bench for dsp_route_sequencer (MODULES=8, LOG_MODULES=4).
// Compile with DSP_ROUTE_TRIG_EN to exercise the hardware trigger.
module tb_dsp_route_sequencer;

  logic        clk_i;
  logic        rst_i;
  logic        trig;
  logic [47:0] sel;
  logic [19:0] osel;
  logic        mute;
  logic        busy;
  int          n_vec;
  int          n_bad;

  dsp_route_sequencer_if bus ();

  dsp_route_sequencer #(.MODULES(8), .LOG_MODULES(4)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
`ifdef DSP_ROUTE_TRIG_EN
    .trig_i (trig),
`endif
    .bus    (bus),
    .sel_o  (sel),
    .osel_o (osel),
    .mute_o (mute),
    .busy_o (busy)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_i         = 1'b1;
    trig          = 1'b0;
    bus.sys_addr  = '0;
    bus.sys_wdata = '0;
    bus.sys_wen   = 1'b0;
    bus.sys_ren   = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.sys_addr  = a;
    bus.sys_wdata = d;
    bus.sys_wen   = 1'b1;
    @(negedge clk_i);
    bus.sys_wen = 1'b0;
    check("wr_ack", 32'(bus.sys_ack), 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.sys_addr = a;
    bus.sys_ren  = 1'b1;
    @(negedge clk_i);
    bus.sys_ren = 1'b0;
    check("rd_ack", 32'(bus.sys_ack), 32'd1);
    d = bus.sys_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  mbits;
    logic [7:0]  bbits;
    int          first_apply;
    int          rises;
    int          idle_run;
    logic        prev;

    n_vec = 0;
    n_bad = 0;

    // Reset state
    do_reset();
    check("rst_sel0", 32'(sel[3:0]), 32'd10);
    check("rst_sel1", 32'(sel[7:4]), 32'd11);
    check("rst_sel11", 32'(sel[47:44]), 32'd15);
    check("rst_osel", 32'(osel), 32'd0);
    check("rst_mute", 32'(mute), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(bus.sys_ack), 32'd0);
    check("sys_err", 32'(bus.sys_err), 32'd0);
    bus_read(32'h00, rd); check("rd_0x00", rd, 32'd10);
    bus_read(32'h04, rd); check("rd_0x04", rd, 32'd11);
    bus_read(32'h24, rd); check("rd_0x24", rd, 32'd11);
    bus_read(32'h2C, rd); check("rd_0x2C", rd, 32'd15);
    @(negedge clk_i);
    check("ack_drop", 32'(bus.sys_ack), 32'd0);
    bus_read(32'h8C, rd); check("rst_commits", rd, 32'd0);
    bus_write(32'h90, 32'hFFFF);
    bus_read(32'h90, rd); check("unmapped", rd, 32'd0);
    bus_write(32'h48, 32'h2);
    bus_read(32'h48, rd); check("osel_shadow", rd, 32'd2);

    // Full sequence with MUTE_CYC=3
    bus_write(32'h00, 32'd4);
    bus_write(32'h84, 32'd3);
    bus_read(32'h84, rd); check("mute_cyc_rd", rd, 32'd3);
    bus_read(32'h00, rd); check("shadow0_rd", rd, 32'd4);
    check("active_held", 32'(sel[3:0]), 32'd10);
    bus_write(32'h80, 32'd1);
    first_apply = -1;
    for (int i = 0; i < 8; i++) begin
      mbits[i] = mute;
      bbits[i] = busy;
      if (first_apply < 0 && sel[3:0] == 4'd4) first_apply = i;
      @(negedge clk_i);
    end
    check("seq_mute", 32'(mbits), 32'h7F);
    check("seq_busy", 32'(bbits), 32'h7F);
    check("seq_apply_at", 32'(first_apply), 32'd3);
    check("seq_osel", 32'(osel), 32'h20);
    bus_read(32'h8C, rd); check("seq_commits", rd, 32'd1);

    // Repeated commits during MUTE queue exactly one more sequence
    do_reset();
    bus_write(32'h84, 32'd3);
    bus_write(32'h00, 32'd5);
    bus_write(32'h80, 32'd1);
    bus_write(32'h80, 32'd1);
    bus_read(32'h88, rd); check("pend_status", rd, 32'd3);
    bus_write(32'h80, 32'd1);
    rises    = 0;
    idle_run = 0;
    prev     = 1'b0;
    for (int i = 0; i < 60 && idle_run < 3; i++) begin
      if (mute && !prev) rises++;
      prev     = mute;
      idle_run = busy ? 0 : idle_run + 1;
      @(negedge clk_i);
    end
    check("pend_done", 32'(idle_run >= 3), 32'd1);
    check("pend_mute_rises", 32'(rises), 32'd2);
    bus_read(32'h8C, rd); check("pend_commits", rd, 32'd2);
    bus_read(32'h88, rd); check("pend_clear", rd, 32'd0);
    check("pend_sel0", 32'(sel[3:0]), 32'd5);

    // MUTE_CYC=0: immediate apply, no mute
    do_reset();
    bus_write(32'h08, 32'd7);
    bus_write(32'h40, 32'd3);
    check("z_pre_sel2", 32'(sel[11:8]), 32'd10);
    bus_write(32'h80, 32'd1);
    check("z_sel2", 32'(sel[11:8]), 32'd7);
    check("z_osel0", 32'(osel[1:0]), 32'd3);
    check("z_mute", 32'(mute), 32'd0);
    check("z_busy", 32'(busy), 32'd1);
    @(negedge clk_i);
    check("z_mute2", 32'(mute), 32'd0);
    check("z_busy2", 32'(busy), 32'd0);
    bus_read(32'h8C, rd); check("z_commits", rd, 32'd1);

    // Reset during SETTLE
    do_reset();
    bus_write(32'h84, 32'd3);
    bus_write(32'h00, 32'd6);
    bus_write(32'h80, 32'd1);
    repeat (4) @(negedge clk_i);
    check("rs_sel0", 32'(sel[3:0]), 32'd6);
    check("rs_mute", 32'(mute), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rs_mute_async", 32'(mute), 32'd0);
    check("rs_sel0_async", 32'(sel[3:0]), 32'd10);
    check("rs_busy_async", 32'(busy), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    bus_read(32'h8C, rd); check("rs_commits", rd, 32'd0);
    bus_read(32'h00, rd); check("rs_shadow0", rd, 32'd10);
    bus_read(32'h84, rd); check("rs_mute_cyc", rd, 32'd0);

`ifdef DSP_ROUTE_TRIG_EN
    // Armed trigger: two pulses, one sequence
    do_reset();
    bus_write(32'h00, 32'd9);
    bus_write(32'h80, 32'd2);
    bus_read(32'h88, rd); check("tr_armed", rd, 32'd4);
    for (int p = 0; p < 2; p++) begin
      trig = 1'b1;
      @(negedge clk_i);
      trig = 1'b0;
      repeat (5) @(negedge clk_i);
    end
    check("tr_sel0", 32'(sel[3:0]), 32'd9);
    bus_read(32'h8C, rd); check("tr_commits", rd, 32'd1);
    bus_read(32'h88, rd); check("tr_disarmed", rd, 32'd0);
`else
    // CTRL bit1 has no effect without the trigger option
    do_reset();
    bus_write(32'h80, 32'd2);
    bus_read(32'h88, rd); check("notr_status", rd, 32'd0);
    bus_read(32'h8C, rd); check("notr_commits", rd, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
